csr_file: RTL and testbench

- Machine-mode CSR register file for the core.
- Serves two independent access ports:
  - The execute-stage port, used by CSRRW/CSRRS/CSRRC write-back and by reads.
  - The interrupt-controller port, which writes mepc, mstatus and mcause during trap entry and return.
- Exports mtvec, mepc, mstatus and the global interrupt enable directly to the interrupt controller.
- Runs the 64-bit cycle counter.

---
 rtl/csr_file.sv | 170 +++++++++++++++++
 tb/tb_csr_file.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file with two write/read ports
// (execute stage and interrupt controller) and a 64-bit cycle counter.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
    parameter logic [31:0] RESET_MSTATUS = 32'h0000_0088
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] raddr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        clint_we_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_raddr_i,
    input  logic [31:0] clint_data_i,
    output logic [31:0] clint_data_o,
    output logic [31:0] clint_csr_mtvec,
    output logic [31:0] clint_csr_mepc,
    output logic [31:0] clint_csr_mstatus,
    output logic [31:0] mie_o,
    output logic        global_int_en_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] cycle_q, cycle_d;

    logic        cyc_lo_wr, cyc_hi_wr;
    logic [31:0] cyc_lo_val, cyc_hi_val;
    logic [31:0] ex_rd, cl_rd;

    function automatic logic writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MCYCLE, A_MCYCLEH: writable = 1'b1;
            default:                               writable = 1'b0;
        endcase
    endfunction

    // mepc is word aligned: low two bits never stored or forwarded
    function automatic logic [31:0] fwd_val(input logic [11:0] a, input logic [31:0] d);
        fwd_val = (a == A_MEPC) ? {d[31:2], 2'b00} : d;
    endfunction

    // Next-state: interrupt port applied first so the execute port overrides it on a shared address
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        cyc_lo_wr  = 1'b0;
        cyc_hi_wr  = 1'b0;
        cyc_lo_val = '0;
        cyc_hi_val = '0;
        if (clint_we_i) begin
            case (clint_waddr_i[11:0])
                A_MSTATUS:  mstatus_d  = clint_data_i;
                A_MIE:      mie_d      = clint_data_i;
                A_MTVEC:    mtvec_d    = clint_data_i;
                A_MSCRATCH: mscratch_d = clint_data_i;
                A_MEPC:     mepc_d     = {clint_data_i[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = clint_data_i;
                A_MCYCLE:   begin cyc_lo_wr = 1'b1; cyc_lo_val = clint_data_i; end
                A_MCYCLEH:  begin cyc_hi_wr = 1'b1; cyc_hi_val = clint_data_i; end
                default:    ;
            endcase
        end
        if (we_i) begin
            case (waddr_i[11:0])
                A_MSTATUS:  mstatus_d  = data_i;
                A_MIE:      mie_d      = data_i;
                A_MTVEC:    mtvec_d    = data_i;
                A_MSCRATCH: mscratch_d = data_i;
                A_MEPC:     mepc_d     = {data_i[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = data_i;
                A_MCYCLE:   begin cyc_lo_wr = 1'b1; cyc_lo_val = data_i; end
                A_MCYCLEH:  begin cyc_hi_wr = 1'b1; cyc_hi_val = data_i; end
                default:    ;
            endcase
        end
        if (cyc_lo_wr || cyc_hi_wr)
            cycle_d = {cyc_hi_wr ? cyc_hi_val : cycle_q[63:32],
                       cyc_lo_wr ? cyc_lo_val : cycle_q[31:0]};
        else
            cycle_d = cycle_q + 64'd1;
    end

    // Execute-port read mux with same-port write forwarding
    always_comb begin
        case (raddr_i[11:0])
            A_MSTATUS:           ex_rd = mstatus_q;
            A_MIE:               ex_rd = mie_q;
            A_MTVEC:             ex_rd = mtvec_q;
            A_MSCRATCH:          ex_rd = mscratch_q;
            A_MEPC:              ex_rd = mepc_q;
            A_MCAUSE:            ex_rd = mcause_q;
            A_MCYCLE, A_CYCLE:   ex_rd = cycle_q[31:0];
            A_MCYCLEH, A_CYCLEH: ex_rd = cycle_q[63:32];
            default:             ex_rd = '0;
        endcase
        data_o = ex_rd;
        if (we_i && (waddr_i[11:0] == raddr_i[11:0]) && writable(waddr_i[11:0]))
            data_o = fwd_val(waddr_i[11:0], data_i);
    end

    // Interrupt-port read mux with same-port write forwarding
    always_comb begin
        case (clint_raddr_i[11:0])
            A_MSTATUS:           cl_rd = mstatus_q;
            A_MIE:               cl_rd = mie_q;
            A_MTVEC:             cl_rd = mtvec_q;
            A_MSCRATCH:          cl_rd = mscratch_q;
            A_MEPC:              cl_rd = mepc_q;
            A_MCAUSE:            cl_rd = mcause_q;
            A_MCYCLE, A_CYCLE:   cl_rd = cycle_q[31:0];
            A_MCYCLEH, A_CYCLEH: cl_rd = cycle_q[63:32];
            default:             cl_rd = '0;
        endcase
        clint_data_o = cl_rd;
        if (clint_we_i && (clint_waddr_i[11:0] == clint_raddr_i[11:0]) && writable(clint_waddr_i[11:0]))
            clint_data_o = fwd_val(clint_waddr_i[11:0], clint_data_i);
    end

    // CSR state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= RESET_MSTATUS;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            cycle_q    <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            cycle_q    <= cycle_d;
        end
    end

    assign clint_csr_mtvec   = mtvec_q;
    assign clint_csr_mepc    = mepc_q;
    assign clint_csr_mstatus = mstatus_q;
    assign mie_o             = mie_q;
    assign global_int_en_o   = mstatus_q[3];

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed-vector bench for csr_file with hand-computed expectations.
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] waddr_i;
    logic [31:0] raddr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        clint_we_i;
    logic [31:0] clint_waddr_i;
    logic [31:0] clint_raddr_i;
    logic [31:0] clint_data_i;
    logic [31:0] clint_data_o;
    logic [31:0] clint_csr_mtvec;
    logic [31:0] clint_csr_mepc;
    logic [31:0] clint_csr_mstatus;
    logic [31:0] mie_o;
    logic        global_int_en_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    csr_file #(
        .RESET_MTVEC   (32'h0000_0000),
        .RESET_MSTATUS (32'h0000_0088)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .raddr_i           (raddr_i),
        .data_i            (data_i),
        .data_o            (data_o),
        .clint_we_i        (clint_we_i),
        .clint_waddr_i     (clint_waddr_i),
        .clint_raddr_i     (clint_raddr_i),
        .clint_data_i      (clint_data_i),
        .clint_data_o      (clint_data_o),
        .clint_csr_mtvec   (clint_csr_mtvec),
        .clint_csr_mepc    (clint_csr_mepc),
        .clint_csr_mstatus (clint_csr_mstatus),
        .mie_o             (mie_o),
        .global_int_en_o   (global_int_en_o)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; we_i = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0;
        clint_we_i = 1'b0; clint_waddr_i = '0; clint_raddr_i = '0; clint_data_i = '0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_mtvec",   clint_csr_mtvec,   32'h0000_0000);
        check("rst_mepc",    clint_csr_mepc,    32'h0000_0000);
        check("rst_mstatus", clint_csr_mstatus, 32'h0000_0088);
        check("rst_gie",     {31'd0, global_int_en_o}, 32'd1);
        check("rst_mie",     mie_o, 32'h0);

        // Release; counter reads 0 then 1
        step();
        rst = 1'b0; raddr_i = 32'hB00;
        #1 check("cyc_first", data_o, 32'd0);
        step();
        check("cyc_second", data_o, 32'd1);

        // Execute write to mtvec with same-cycle forwarded read
        we_i = 1'b1; waddr_i = 32'h305; data_i = 32'h8000_0100; raddr_i = 32'h305;
        #1 check("mtvec_fwd", data_o, 32'h8000_0100);
        check("mtvec_out_pre", clint_csr_mtvec, 32'h0000_0000);
        step();
        we_i = 1'b0;
        #1 check("mtvec_rd", data_o, 32'h8000_0100);
        check("mtvec_out", clint_csr_mtvec, 32'h8000_0100);

        // Interrupt-port trap sequence
        clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_data_i = 32'h0000_1236; clint_raddr_i = 32'h341;
        #1 check("mepc_clint_fwd", clint_data_o, 32'h0000_1234);
        step();
        clint_waddr_i = 32'h300; clint_data_i = 32'h0000_0080;
        #1 check("mepc_out", clint_csr_mepc, 32'h0000_1234);
        check("gie_before", {31'd0, global_int_en_o}, 32'd1);
        step();
        clint_waddr_i = 32'h342; clint_data_i = 32'h8000_0004;
        #1 check("gie_after", {31'd0, global_int_en_o}, 32'd0);
        check("mstatus_out", clint_csr_mstatus, 32'h0000_0080);
        step();
        clint_we_i = 1'b0; raddr_i = 32'h342; clint_raddr_i = 32'h341;
        #1 check("mcause_rd", data_o, 32'h8000_0004);
        check("mepc_rd", clint_data_o, 32'h0000_1234);

        // Same-address collision: execute port wins
        we_i = 1'b1; waddr_i = 32'h340; data_i = 32'hAAAA_AAAA;
        clint_we_i = 1'b1; clint_waddr_i = 32'h340; clint_data_i = 32'h5555_5555;
        step();
        we_i = 1'b0; clint_we_i = 1'b0; raddr_i = 32'h340;
        #1 check("collide_mscratch", data_o, 32'hAAAA_AAAA);

        // Different addresses: both commit (mepc low bits cleared)
        we_i = 1'b1; waddr_i = 32'h340; data_i = 32'h1111_1111;
        clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_data_i = 32'h2222_2223;
        step();
        we_i = 1'b0; clint_we_i = 1'b0; raddr_i = 32'h340; clint_raddr_i = 32'h341;
        #1 check("dual_mscratch", data_o, 32'h1111_1111);
        check("dual_mepc", clint_data_o, 32'h2222_2220);

        // mie write using an address with undecoded upper bits set
        we_i = 1'b1; waddr_i = 32'h0001_0304; data_i = 32'h0000_0888;
        step();
        we_i = 1'b0;
        #1 check("mie_out", mie_o, 32'h0000_0888);

        // Counter load, wrap of the low half into the high half
        raddr_i = 32'hB80;
        #1 check("mcycleh_zero", data_o, 32'h0);
        we_i = 1'b1; waddr_i = 32'hB00; data_i = 32'hFFFF_FFFF;
        step();
        we_i = 1'b0; raddr_i = 32'hB00; clint_raddr_i = 32'hB80;
        #1 check("mcycle_loaded", data_o, 32'hFFFF_FFFF);
        check("mcycleh_held", clint_data_o, 32'h0);
        step();
        raddr_i = 32'hC00; clint_raddr_i = 32'hC80;
        we_i = 1'b1; waddr_i = 32'hC00; data_i = 32'h0000_1234;
        #1 check("cycle_wrapped", data_o, 32'h0);
        check("cycleh_carry", clint_data_o, 32'h1);
        step();
        we_i = 1'b0;
        #1 check("cycle_ro_ignored", data_o, 32'h1);
        check("cycleh_after_ro", clint_data_o, 32'h1);

        // Unmapped address: read 0, no forwarding, no side effects
        we_i = 1'b1; waddr_i = 32'h7C0; data_i = 32'hDEAD_BEEF; raddr_i = 32'h7C0;
        #1 check("unmapped_nofwd", data_o, 32'h0);
        step();
        we_i = 1'b0; clint_raddr_i = 32'h340;
        #1 check("unmapped_rd", data_o, 32'h0);
        check("unmapped_mscratch", clint_data_o, 32'h1111_1111);
        check("unmapped_mtvec", clint_csr_mtvec, 32'h8000_0100);
        check("unmapped_mstatus", clint_csr_mstatus, 32'h0000_0080);
        check("unmapped_mie", mie_o, 32'h0000_0888);

        // Mid-cycle reset with an in-flight write
        we_i = 1'b1; waddr_i = 32'h340; data_i = 32'h9999_9999;
        #2 rst = 1'b1;
        #1 check("mid_rst_mtvec", clint_csr_mtvec, 32'h0000_0000);
        check("mid_rst_mstatus", clint_csr_mstatus, 32'h0000_0088);
        check("mid_rst_mepc", clint_csr_mepc, 32'h0000_0000);
        check("mid_rst_mie", mie_o, 32'h0);
        check("mid_rst_gie", {31'd0, global_int_en_o}, 32'd1);
        step();
        we_i = 1'b0; raddr_i = 32'h340; clint_raddr_i = 32'h342;
        #1 check("mid_rst_mscratch", data_o, 32'h0);
        check("mid_rst_mcause", clint_data_o, 32'h0);
        raddr_i = 32'hB00;
        #1 check("mid_rst_cycle", data_o, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_cycle", data_o, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
